// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and default opcode width shared by the ALU slice
package alu_pkg;
    localparam int ALU_NSEL = 6;
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU datapath producing result and signed overflow
//   i_a, i_b   : operands (i_b is an unsigned shift amount for shifts)
//   i_op       : operation select
//   o_result   : wrapped N-bit result, 0 for undefined opcodes
//   o_overflow : signed overflow, ADD/SUB only
module alu_core
    import alu_pkg::*;
#(
    parameter int N    = 8,
    parameter int NSel = ALU_NSEL
) (
    input  logic [N-1:0]    i_a,
    input  logic [N-1:0]    i_b,
    input  logic [NSel-1:0] i_op,
    output logic [N-1:0]    o_result,
    output logic            o_overflow
);
    logic [N-1:0] w_sum;
    logic [N-1:0] w_diff;
    logic [N-1:0] w_sra;
    logic [N-1:0] w_srl;
    logic         w_add_ovf;
    logic         w_sub_ovf;
    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;
    // Shift amounts of N or more naturally saturate: zeros for >>, sign copies for >>>
    assign w_srl  = i_a >> i_b;
    assign w_sra  = $unsigned($signed(i_a) >>> i_b);
    assign w_add_ovf = (i_a[N-1] == i_b[N-1]) && (w_sum[N-1]  != i_a[N-1]);
    assign w_sub_ovf = (i_a[N-1] != i_b[N-1]) && (w_diff[N-1] != i_a[N-1]);
    always_comb begin
        o_result   = i_op == NSel'(OP_ADD) ? w_sum :
                     i_op == NSel'(OP_SUB) ? w_diff :
                     i_op == NSel'(OP_AND) ? i_a & i_b :
                     i_op == NSel'(OP_OR)  ? i_a | i_b :
                     i_op == NSel'(OP_XOR) ? i_a ^ i_b :
                     i_op == NSel'(OP_SRA) ? w_sra :
                     i_op == NSel'(OP_SRL) ? w_srl :
                     i_op == NSel'(OP_NOR) ? ~(i_a | i_b) : '0;
        o_overflow = i_op == NSel'(OP_ADD) ? w_add_ovf :
                     i_op == NSel'(OP_SUB) ? w_sub_ovf : 1'b0;
    end
endmodule

// File: rtl/alu.sv
// alu: registered ALU with overflow and zero flags, one-cycle latency
//   i_clock, i_reset     : clock, synchronous active-high reset
//   i_alu_A, i_alu_B     : operands
//   i_alu_Op             : operation select
//   o_alu_Result         : registered result
//   o_overflow_Flag      : registered signed overflow
//   o_zero_Flag          : registered result-is-zero flag
module alu
    import alu_pkg::*;
#(
    parameter int N    = 8,
    parameter int NSel = ALU_NSEL
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic [N-1:0]    i_alu_A,
    input  logic [N-1:0]    i_alu_B,
    input  logic [NSel-1:0] i_alu_Op,
    output logic [N-1:0]    o_alu_Result,
    output logic            o_overflow_Flag,
    output logic            o_zero_Flag
);
    logic [N-1:0] w_result;
    logic         w_overflow;
    logic [N-1:0] r_result;
    logic         r_overflow;
    logic         r_zero;
    alu_core #(.N(N), .NSel(NSel)) u_core (
        .i_a        (i_alu_A),
        .i_b        (i_alu_B),
        .i_op       (i_alu_Op),
        .o_result   (w_result),
        .o_overflow (w_overflow)
    );
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b1;
        end else begin
            r_result   <= w_result;
            r_overflow <= w_overflow;
            r_zero     <= w_result == '0;
        end
    end
    assign o_alu_Result    = r_result;
    assign o_overflow_Flag = r_overflow;
    assign o_zero_Flag     = r_zero;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu at N=5, NSel=6
module tb_alu;
    logic       i_clock;
    logic       i_reset;
    logic [4:0] i_alu_A;
    logic [4:0] i_alu_B;
    logic [5:0] i_alu_Op;
    logic [4:0] o_alu_Result;
    logic       o_overflow_Flag;
    logic       o_zero_Flag;
    int n_pass = 0;
    int n_total = 0;
    alu #(.N(5), .NSel(6)) dut (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_alu_A         (i_alu_A),
        .i_alu_B         (i_alu_B),
        .i_alu_Op        (i_alu_Op),
        .o_alu_Result    (o_alu_Result),
        .o_overflow_Flag (o_overflow_Flag),
        .o_zero_Flag     (o_zero_Flag)
    );
    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask
    task automatic vec(input string tag, input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] er, input logic eo, input logic ez);
        @(negedge i_clock);
        i_alu_Op = op;
        i_alu_A  = a;
        i_alu_B  = b;
        @(posedge i_clock);
        #1;
        check({tag, ".res"}, {3'b0, o_alu_Result}, {3'b0, er});
        check({tag, ".ovf"}, {7'b0, o_overflow_Flag}, {7'b0, eo});
        check({tag, ".z"}, {7'b0, o_zero_Flag}, {7'b0, ez});
    endtask
    initial begin
        i_reset  = 1'b1;
        i_alu_Op = 6'b100000;
        i_alu_A  = 5'd3;
        i_alu_B  = 5'd4;
        @(posedge i_clock);
        #1;
        check("rst.res", {3'b0, o_alu_Result}, 8'd0);
        check("rst.ovf", {7'b0, o_overflow_Flag}, 8'd0);
        check("rst.z", {7'b0, o_zero_Flag}, 8'd1);
        @(negedge i_clock);
        i_reset = 1'b0;
        @(posedge i_clock);
        #1;
        check("post_rst.res", {3'b0, o_alu_Result}, 8'd7);
        check("post_rst.z", {7'b0, o_zero_Flag}, 8'd0);
        vec("sub7_3",   6'b100010, 5'd7,      5'd3,      5'd4,      1'b0, 1'b0);
        vec("add15_1",  6'b100000, 5'd15,     5'd1,      5'b10000,  1'b1, 1'b0);
        vec("subm16_1", 6'b100010, 5'b10000,  5'd1,      5'd15,     1'b1, 1'b0);
        vec("sub5_5",   6'b100010, 5'd5,      5'd5,      5'd0,      1'b0, 1'b1);
        vec("nor",      6'b100111, 5'b11111,  5'b00000,  5'd0,      1'b0, 1'b1);
        vec("and",      6'b100100, 5'b10110,  5'b01100,  5'b00100,  1'b0, 1'b0);
        vec("or",       6'b100101, 5'b10110,  5'b01100,  5'b11110,  1'b0, 1'b0);
        vec("xor",      6'b100110, 5'b10110,  5'b01100,  5'b11010,  1'b0, 1'b0);
        vec("sra1",     6'b000011, 5'b11000,  5'd1,      5'b11100,  1'b0, 1'b0);
        vec("srl1",     6'b000010, 5'b11000,  5'd1,      5'b01100,  1'b0, 1'b0);
        vec("srl7",     6'b000010, 5'b11000,  5'd7,      5'd0,      1'b0, 1'b1);
        vec("sra7",     6'b000011, 5'b11000,  5'd7,      5'b11111,  1'b0, 1'b0);
        vec("add_neg",  6'b100000, 5'b10000,  5'b11111,  5'b01111,  1'b1, 1'b0);
        vec("sub_noov", 6'b100010, 5'b11000,  5'd3,      5'b10101,  1'b0, 1'b0);
        vec("badop",    6'b111111, 5'd3,      5'd4,      5'd0,      1'b0, 1'b1);
        vec("add_wrap", 6'b100000, 5'b11111,  5'd1,      5'd0,      1'b0, 1'b1);
        // change inputs mid-cycle: registered outputs must hold until the next edge
        @(negedge i_clock);
        i_alu_Op = 6'b100000;
        i_alu_A  = 5'd2;
        i_alu_B  = 5'd3;
        #2;
        check("hold.res", {3'b0, o_alu_Result}, 8'd0);
        check("hold.z", {7'b0, o_zero_Flag}, 8'd1);
        @(posedge i_clock);
        #1;
        check("hold_next.res", {3'b0, o_alu_Result}, 8'd5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
